// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I+MUL control sequencer.
// Contents: FSM state enum, ALU operation codes, opcode / funct constants
// and the operand, writeback and next-PC select encodings.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExec,
        StWb,
        StAddr,
        StMem,
        StBranch,
        StJump,
        StTrap
    } ctrl_state_e;

    // ALU operation codes
    localparam logic [3:0] AluAdd  = 4'h0;
    localparam logic [3:0] AluSub  = 4'h1;
    localparam logic [3:0] AluMul  = 4'h2;
    localparam logic [3:0] AluAnd  = 4'h3;
    localparam logic [3:0] AluOr   = 4'h4;
    localparam logic [3:0] AluXor  = 4'h5;
    localparam logic [3:0] AluSll  = 4'h6;
    localparam logic [3:0] AluSrl  = 4'h7;
    localparam logic [3:0] AluSra  = 4'h8;
    localparam logic [3:0] AluSlt  = 4'h9;
    localparam logic [3:0] AluSltu = 4'hA;
    localparam logic [3:0] AluBeq  = 4'hB;
    localparam logic [3:0] AluBne  = 4'hC;
    localparam logic [3:0] AluBlt  = 4'hD;
    localparam logic [3:0] AluBge  = 4'hE;
    localparam logic [3:0] AluBgeu = 4'hF;

    // Major opcodes
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    // funct7 variants
    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mul  = 7'b0000001;

    localparam logic [2:0] F3Bltu = 3'b110;

    // Operand A select
    localparam logic [1:0] SrcARs1  = 2'd0;
    localparam logic [1:0] SrcAPc   = 2'd1;
    localparam logic [1:0] SrcAZero = 2'd2;

    // Operand B select
    localparam logic [1:0] SrcBRs2 = 2'd0;
    localparam logic [1:0] SrcBImm = 2'd1;

    // Writeback source select
    localparam logic [1:0] WbAlu  = 2'd0;
    localparam logic [1:0] WbLoad = 2'd1;
    localparam logic [1:0] WbPc4  = 2'd2;

    // Next-PC select
    localparam logic PcPlus4 = 1'b0;
    localparam logic PcAlu   = 1'b1;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decoder: opcode/funct3/funct7 -> ALU code and
// a legality bit. Serves both the EXEC path (OP / OP-IMM) and the BRANCH
// path (compare codes); address and link computations decode to add.
// Ports:
//   opcode_i  major opcode (ir[6:0])
//   funct3_i  ir[14:12]
//   funct7_i  ir[31:25]
//   alu_op_o  ALU operation code
//   legal_o   1 when the encoding is supported
module alu_op_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_op_o,
    output logic       legal_o
);

    logic is_op;

    assign is_op = (opcode_i == OpcOp);

    always_comb begin
        alu_op_o = AluAdd;
        legal_o  = 1'b1;
        case (opcode_i)
            OpcOp, OpcOpImm: begin
                case (funct3_i)
                    3'b000: begin
                        // OP-IMM funct7 bits are immediate bits, so only OP picks sub/mul
                        if (is_op && funct7_i == F7Alt) begin
                            alu_op_o = AluSub;
                        end else if (is_op && funct7_i == F7Mul) begin
                            alu_op_o = AluMul;
                        end else begin
                            alu_op_o = AluAdd;
                        end
                    end
                    3'b001:  alu_op_o = AluSll;
                    3'b010:  alu_op_o = AluSlt;
                    3'b011:  alu_op_o = AluSltu;
                    3'b100:  alu_op_o = AluXor;
                    3'b101:  alu_op_o = funct7_i[5] ? AluSra : AluSrl;
                    3'b110:  alu_op_o = AluOr;
                    default: alu_op_o = AluAnd;
                endcase
                if (is_op) begin
                    legal_o = (funct7_i == F7Base) ||
                              (funct7_i == F7Alt && (funct3_i == 3'b000 || funct3_i == 3'b101)) ||
                              (funct7_i == F7Mul && funct3_i == 3'b000);
                end else if (funct3_i == 3'b001) begin
                    legal_o = (funct7_i == F7Base);
                end else if (funct3_i == 3'b101) begin
                    legal_o = (funct7_i == F7Base) || (funct7_i == F7Alt);
                end
            end
            OpcBranch: begin
                case (funct3_i)
                    3'b000:  alu_op_o = AluBeq;
                    3'b001:  alu_op_o = AluBne;
                    3'b100:  alu_op_o = AluBlt;
                    3'b101:  alu_op_o = AluBge;
                    3'b110:  alu_op_o = AluSltu;
                    3'b111:  alu_op_o = AluBgeu;
                    default: legal_o  = 1'b0;
                endcase
            end
            OpcLui, OpcAuipc, OpcLoad, OpcStore, OpcJal, OpcJalr: alu_op_o = AluAdd;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32I+MUL datapath. Latches each
// fetched instruction and steps it through FETCH/DECODE/EXEC/WB, ADDR/MEM,
// BRANCH or JUMP, driving ALU code, operand selects and datapath strobes.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   instr_valid, instr    instruction memory response
//   mem_ready             data memory access completes this cycle
//   alu_zero/less_than    ALU flags used to resolve branches
//   instr_req             fetch request
//   ir                    latched instruction
//   alu_op, alu_src_a/b   ALU operation and operand selects
//   reg_write, wb_sel     register-file write strobe and source
//   mem_read, mem_write   data memory strobes
//   pc_write, pc_src      PC update strobe and next-PC select
//   illegal               sticky illegal-instruction flag
module multicycle_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_less_than,
    output logic        instr_req,
    output logic [31:0] ir,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        mem_read,
    output logic        mem_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        illegal
);

    import rv_ctrl_pkg::*;

    ctrl_state_e state_q;
    logic [31:0] ir_q;
    logic        illegal_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] dec_alu_op;
    logic       dec_legal;
    logic       is_load;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign is_load = (opcode == OpcLoad);

    alu_op_decode u_alu_op_decode (
        .opcode_i (opcode),
        .funct3_i (funct3),
        .funct7_i (ir_q[31:25]),
        .alu_op_o (dec_alu_op),
        .legal_o  (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            ir_q      <= NOP_INSTR;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (instr_valid) begin
                        ir_q    <= instr;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    if (!dec_legal) begin
                        state_q   <= StTrap;
                        illegal_q <= 1'b1;
                    end else begin
                        case (opcode)
                            OpcOp, OpcOpImm, OpcLui, OpcAuipc: state_q <= StExec;
                            OpcLoad, OpcStore:                 state_q <= StAddr;
                            OpcBranch:                         state_q <= StBranch;
                            OpcJal, OpcJalr:                   state_q <= StJump;
                            default: begin
                                state_q   <= StTrap;
                                illegal_q <= 1'b1;
                            end
                        endcase
                    end
                end
                StExec: state_q <= StWb;
                StWb:   state_q <= StFetch;
                StAddr: state_q <= StMem;
                StMem: begin
                    if (mem_ready) begin
                        state_q <= is_load ? StWb : StFetch;
                    end
                end
                StBranch, StJump: state_q <= StFetch;
                StTrap:           state_q <= StTrap;
                default:          state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        instr_req = 1'b0;
        alu_op    = AluAdd;
        alu_src_a = SrcARs1;
        alu_src_b = SrcBRs2;
        reg_write = 1'b0;
        wb_sel    = WbAlu;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PcPlus4;
        unique case (state_q)
            // Request is held off while reset is asserted
            StFetch: instr_req = rst_n;
            StDecode: begin
            end
            StExec: begin
                alu_op = dec_alu_op;
                if (opcode == OpcLui) begin
                    alu_src_a = SrcAZero;
                    alu_src_b = SrcBImm;
                end else if (opcode == OpcAuipc) begin
                    alu_src_a = SrcAPc;
                    alu_src_b = SrcBImm;
                end else if (opcode == OpcOpImm) begin
                    alu_src_b = SrcBImm;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                wb_sel    = is_load ? WbLoad : WbAlu;
                pc_write  = 1'b1;
            end
            StAddr: alu_src_b = SrcBImm;
            StMem: begin
                alu_src_b = SrcBImm;
                mem_read  = is_load;
                mem_write = !is_load;
                // A store retires here; a load retires in WB
                pc_write  = !is_load && mem_ready;
            end
            StBranch: begin
                alu_op   = dec_alu_op;
                pc_write = 1'b1;
                pc_src   = (funct3 == F3Bltu) ? alu_less_than : alu_zero;
            end
            StJump: begin
                reg_write = 1'b1;
                wb_sel    = WbPc4;
                alu_src_a = (opcode == OpcJal) ? SrcAPc : SrcARs1;
                alu_src_b = SrcBImm;
                pc_write  = 1'b1;
                pc_src    = PcAlu;
            end
            StTrap: begin
            end
            default: begin
            end
        endcase
    end

    assign ir      = ir_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic        alu_less_than;
    logic        instr_req;
    logic [31:0] ir;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        mem_read;
    logic        mem_write;
    logic        pc_write;
    logic        pc_src;
    logic        illegal;

    multicycle_ctrl #(.NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .mem_ready     (mem_ready),
        .alu_zero      (alu_zero),
        .alu_less_than (alu_less_than),
        .instr_req     (instr_req),
        .ir            (ir),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        instr_req;
        logic [3:0]  alu_op;
        logic [1:0]  alu_src_a;
        logic [1:0]  alu_src_b;
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic        mem_read;
        logic        mem_write;
        logic        pc_write;
        logic        pc_src;
        logic        illegal;
        logic [31:0] ir;
    } obs_t;

    typedef struct {
        logic iv;
        logic mr;
        obs_t exp;
    } cyc_t;

    typedef enum int {CAlu, CLoad, CStore, CBranch, CJump, CIll} cls_e;

    typedef struct {
        string       name;
        logic [31:0] ins;
        int          fw;
        int          mw;
        logic        z;
        logic        lt;
        logic [3:0]  op;
        logic [1:0]  a;
        logic [1:0]  b;
    } vec_t;

    obs_t        act;
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_ir;
    cyc_t        q[$];
    vec_t        tbl[16];

    assign act = {instr_req, alu_op, alu_src_a, alu_src_b, reg_write, wb_sel,
                  mem_read, mem_write, pc_write, pc_src, illegal, ir};

    function automatic obs_t idle(input logic [31:0] w);
        obs_t o;
        o = '0;
        o.ir = w;
        return o;
    endfunction

    // Instruction classes straight from the ISA subset's legality rules
    function automatic cls_e ref_class(input logic [31:0] w);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'h33: return ((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) ||
                           (f7 == 7'h01 && f3 == 0)) ? CAlu : CIll;
            7'h13: begin
                if (f3 == 1) return (f7 == 7'h00) ? CAlu : CIll;
                if (f3 == 5) return (f7 == 7'h00 || f7 == 7'h20) ? CAlu : CIll;
                return CAlu;
            end
            7'h37, 7'h17: return CAlu;
            7'h03: return CLoad;
            7'h23: return CStore;
            7'h63: return (f3 == 2 || f3 == 3) ? CIll : CBranch;
            7'h6f, 7'h67: return CJump;
            default: return CIll;
        endcase
    endfunction

    function automatic logic [3:0] ref_op(input logic [31:0] w);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       is_op;
        f3 = w[14:12];
        f7 = w[31:25];
        is_op = (w[6:0] == 7'h33);
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            case (f3)
                0: return (is_op && f7 == 7'h20) ? 4'h1 : (is_op && f7 == 7'h01) ? 4'h2 : 4'h0;
                1: return 4'h6;
                2: return 4'h9;
                3: return 4'hA;
                4: return 4'h5;
                5: return (f7 == 7'h20) ? 4'h8 : 4'h7;
                6: return 4'h4;
                default: return 4'h3;
            endcase
        end
        if (w[6:0] == 7'h63) begin
            case (f3)
                0: return 4'hB;
                1: return 4'hC;
                4: return 4'hD;
                5: return 4'hE;
                6: return 4'hA;
                default: return 4'hF;
            endcase
        end
        return 4'h0;
    endfunction

    function automatic logic [1:0] ref_a(input logic [31:0] w);
        case (w[6:0])
            7'h37: return 2'd2;
            7'h17, 7'h6f: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] ref_b(input logic [31:0] w);
        return (w[6:0] == 7'h13 || w[6:0] == 7'h37 || w[6:0] == 7'h17) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        for (int t = 0; t < 50; t++) begin
            w = $urandom;
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: w[31:25] = 7'h01;
            endcase
            case ($urandom_range(0, 8))
                0: w[6:0] = 7'h33;
                1: w[6:0] = 7'h13;
                2: w[6:0] = 7'h37;
                3: w[6:0] = 7'h17;
                4: w[6:0] = 7'h03;
                5: w[6:0] = 7'h23;
                6: w[6:0] = 7'h63;
                7: w[6:0] = 7'h6f;
                default: w[6:0] = 7'h67;
            endcase
            if (ref_class(w) != CIll) return w;
        end
        return NOP;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    // Drive one cycle's inputs just after a rising edge, compare at the falling edge
    task automatic step(input string name, input logic iv, input logic [31:0] ins,
                        input logic mr, input obs_t want, output obs_t got);
        instr_valid = iv;
        instr       = ins;
        mem_ready   = mr;
        @(negedge clk);
        got = act;
        check(name, got, want);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic iv, input logic mr, input obs_t e);
        cyc_t c;
        c.iv  = iv;
        c.mr  = mr;
        c.exp = e;
        q.push_back(c);
    endtask

    // Builds the expected cycle-by-cycle timeline of one legal instruction and plays it
    task automatic run_instr(input string name, input logic [31:0] ins, input int fw,
                             input int mw, input logic z, input logic lt,
                             input logic [3:0] op, input logic [1:0] a, input logic [1:0] b);
        obs_t e;
        obs_t got;
        cls_e cls;
        int   strobes;
        cls = ref_class(ins);
        q.delete();
        e = idle(model_ir);
        e.instr_req = 1'b1;
        for (int i = 0; i < fw; i++) push(1'b0, 1'b0, e);
        push(1'b1, 1'b0, e);
        model_ir = ins;
        push(1'($urandom), 1'b0, idle(ins));
        case (cls)
            CAlu: begin
                e = idle(ins);
                e.alu_op = op; e.alu_src_a = a; e.alu_src_b = b;
                push(1'($urandom), 1'b0, e);
                e = idle(ins);
                e.reg_write = 1'b1; e.pc_write = 1'b1;
                push(1'($urandom), 1'b0, e);
            end
            CLoad, CStore: begin
                e = idle(ins);
                e.alu_src_b = 2'd1;
                push(1'($urandom), 1'b0, e);
                e.mem_read  = (cls == CLoad);
                e.mem_write = (cls == CStore);
                for (int i = 0; i < mw; i++) push(1'($urandom), 1'b0, e);
                e.pc_write = (cls == CStore);
                push(1'($urandom), 1'b1, e);
                if (cls == CLoad) begin
                    e = idle(ins);
                    e.reg_write = 1'b1; e.wb_sel = 2'd1; e.pc_write = 1'b1;
                    push(1'($urandom), 1'b0, e);
                end
            end
            CBranch: begin
                e = idle(ins);
                e.alu_op = op; e.pc_write = 1'b1;
                e.pc_src = (ins[14:12] == 3'd6) ? lt : z;
                push(1'($urandom), 1'b0, e);
            end
            default: begin
                e = idle(ins);
                e.reg_write = 1'b1; e.wb_sel = 2'd2; e.alu_src_a = a; e.alu_src_b = 2'd1;
                e.pc_write = 1'b1; e.pc_src = 1'b1;
                push(1'($urandom), 1'b0, e);
            end
        endcase
        alu_zero      = z;
        alu_less_than = lt;
        strobes = 0;
        for (int i = 0; i < q.size(); i++) begin
            step(name, q[i].iv, (i <= fw) ? ins : $urandom, q[i].mr, q[i].exp, got);
            if (got.mem_read || got.mem_write) strobes++;
        end
        if (cls == CLoad || cls == CStore) check_int({name, "_strobe_cycles"}, strobes, mw + 1);
    endtask

    initial begin
        obs_t e;
        obs_t got;
        logic [31:0] w;
        int fw;
        int mw;

        tbl[0]  = '{"add",   32'h002081B3, 0, 0, 1'b0, 1'b0, 4'h0, 2'd0, 2'd0};
        tbl[1]  = '{"sub",   32'h402081B3, 1, 0, 1'b0, 1'b0, 4'h1, 2'd0, 2'd0};
        tbl[2]  = '{"sra",   32'h4020D1B3, 0, 0, 1'b0, 1'b0, 4'h8, 2'd0, 2'd0};
        tbl[3]  = '{"mul",   32'h022081B3, 2, 0, 1'b0, 1'b0, 4'h2, 2'd0, 2'd0};
        tbl[4]  = '{"srai",  32'h4040D193, 0, 0, 1'b0, 1'b0, 4'h8, 2'd0, 2'd1};
        tbl[5]  = '{"sltiu", 32'h0050B193, 0, 0, 1'b0, 1'b0, 4'hA, 2'd0, 2'd1};
        tbl[6]  = '{"lui",   32'h123452B7, 0, 0, 1'b0, 1'b0, 4'h0, 2'd2, 2'd1};
        tbl[7]  = '{"auipc", 32'h00001297, 0, 0, 1'b0, 1'b0, 4'h0, 2'd1, 2'd1};
        tbl[8]  = '{"lw",    32'h0080A203, 0, 3, 1'b0, 1'b0, 4'h0, 2'd0, 2'd1};
        tbl[9]  = '{"sw",    32'h0020A023, 0, 1, 1'b0, 1'b0, 4'h0, 2'd0, 2'd1};
        tbl[10] = '{"bltu",  32'h0020E063, 0, 0, 1'b0, 1'b1, 4'hA, 2'd0, 2'd0};
        tbl[11] = '{"beq",   32'h00208063, 0, 0, 1'b0, 1'b1, 4'hB, 2'd0, 2'd0};
        tbl[12] = '{"bne",   32'h00209063, 1, 0, 1'b1, 1'b0, 4'hC, 2'd0, 2'd0};
        tbl[13] = '{"bge",   32'h0020D063, 0, 0, 1'b0, 1'b1, 4'hE, 2'd0, 2'd0};
        tbl[14] = '{"jal",   32'h000000EF, 0, 0, 1'b0, 1'b0, 4'h0, 2'd1, 2'd1};
        tbl[15] = '{"jalr",  32'h000280E7, 0, 0, 1'b0, 1'b0, 4'h0, 2'd0, 2'd1};

        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        mem_ready = 1'b0;
        alu_zero = 1'b0;
        alu_less_than = 1'b0;
        model_ir = NOP;
        repeat (2) @(posedge clk);
        #1;
        check("reset", act, idle(NOP));
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_instr(tbl[i].name, tbl[i].ins, tbl[i].fw, tbl[i].mw, tbl[i].z, tbl[i].lt,
                      tbl[i].op, tbl[i].a, tbl[i].b);
        end

        for (int i = 0; i < 80; i++) begin
            w  = rand_instr();
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 3);
            run_instr("rand", w, fw, mw, 1'($urandom), 1'($urandom),
                      ref_op(w), ref_a(w), ref_b(w));
        end

        // Illegal OP funct7/funct3 combination: trap, sticky flag, IR frozen
        w = 32'h40209133;
        e = idle(model_ir);
        e.instr_req = 1'b1;
        step("trap_fetch", 1'b1, w, 1'b0, e, got);
        step("trap_decode", 1'b1, $urandom, 1'b0, idle(w), got);
        e = idle(w);
        e.illegal = 1'b1;
        for (int i = 0; i < 3; i++) step("trap_hold", 1'b1, $urandom, 1'b1, e, got);

        rst_n = 1'b0;
        #1;
        check("trap_reset", act, idle(NOP));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_ir = NOP;

        // Store interrupted by reset while waiting in MEM
        w = 32'h0020A023;
        e = idle(NOP);
        e.instr_req = 1'b1;
        step("sr_fetch", 1'b1, w, 1'b0, e, got);
        step("sr_decode", 1'b0, w, 1'b0, idle(w), got);
        e = idle(w);
        e.alu_src_b = 2'd1;
        step("sr_addr", 1'b0, w, 1'b0, e, got);
        e.mem_write = 1'b1;
        step("sr_mem", 1'b0, w, 1'b0, e, got);
        #2;
        check("sr_mem_hold", act, e);
        rst_n = 1'b0;
        #1;
        check("sr_reset", act, idle(NOP));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_ir = NOP;
        run_instr("post_reset_add", 32'h002081B3, 0, 0, 1'b0, 1'b0, 4'h0, 2'd0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RISC-V (RV32I + MUL) datapath: it latches each fetched instruction, steps it through fetch/decode/execute/memory/writeback states, and drives the ALU operation code and operand selects. It also drives register-file, memory and PC strobes. It is the issuing end of the ALU interface and consumes the ALU's `zero` / `less_than` flags to resolve branches.

## Interface
Parameters:
- `NOP_INSTR`, default 32'h0000_0013: IR reset value (`addi x0,x0,0`).

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `instr_valid`  in  1  instruction memory returns `instr` this cycle.
- `instr`  in  32  fetched instruction word.
- `mem_ready`  in  1  data memory completes the pending access this cycle.
- `alu_zero`  in  1  ALU `zero` flag.
- `alu_less_than`  in  1  ALU `less_than` flag.
- `instr_req`  out  1  fetch request.
- `ir`  out  32  latched instruction, feeds the register file and immediate generator.
- `alu_op`  out  4  ALU operation code.
- `alu_src_a`  out  2  operand A select: 0 rs1, 1 PC, 2 zero.
- `alu_src_b`  out  2  operand B select: 0 rs2, 1 immediate.
- `reg_write`  out  1  register-file write strobe.
- `wb_sel`  out  2  writeback source: 0 ALU result, 1 load data, 2 PC+4.
- `mem_read`, `mem_write`  out  1 each  data-memory strobes.
- `pc_write`  out  1  PC update strobe.
- `pc_src`  out  1  next PC: 0 PC+4, 1 ALU result (bit 0 cleared externally for JALR).
- `illegal`  out  1  sticky illegal-instruction flag.

## Operation
- ALU codes: 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, 6 sll, 7 srl, 8 sra, 9 slt, A sltu, B beq, C bne, D blt, E bge, F bgeu.
- FETCH: `instr_req`=1. On `instr_valid`: IR←`instr` and go to DECODE. Otherwise stay.
- DECODE: no strobes. Routes on opcode:
  - OP, OP-IMM, LUI, AUIPC → EXEC.
  - LOAD, STORE → ADDR.
  - BRANCH → BRANCH.
  - JAL, JALR → JUMP.
  - Anything else → TRAP.
- Illegal encodings also go to TRAP. These are:
  - Unrecognized funct7 on OP: only 0000000, 0100000 with funct3 000/101, and 0000001 with funct3 000 are legal.
  - Bad funct7 on SLLI/SRLI/SRAI.
  - BRANCH funct3 010 or 011.
- EXEC: drives the ALU code from funct3/funct7:
  - `alu_src_b`=0 for OP, 1 for OP-IMM.
  - LUI: src_a=2, src_b=1, add. AUIPC: src_a=1, src_b=1, add.
  - Then → WB.
- WB: `reg_write`=1, `wb_sel`=1 if the instruction is a load, else 0. `pc_write`=1, `pc_src`=0. Then → FETCH.
- ADDR: add, src_a=0, src_b=1. Then → MEM.
- MEM: hold `mem_read` (load) or `mem_write` (store) until `mem_ready`, keeping the ADDR ALU selects.
  - Load → WB.
  - Store: `pc_write`=1, `pc_src`=0 in the `mem_ready` cycle, then → FETCH.
- BRANCH: ALU code by funct3: beq B, bne C, blt D, bge E, bltu A, bgeu F. src_a=0, src_b=0.
  - `pc_write`=1.
  - taken = `alu_less_than` for bltu, `alu_zero` otherwise.
  - Branch target comes from the external PC+imm adder on `pc_src`=1 when taken; PC+4 otherwise. Then → FETCH.
- JUMP: `reg_write`=1, `wb_sel`=2, add, src_b=1, src_a=1 (JAL) or 0 (JALR). `pc_write`=1, `pc_src`=1. Then → FETCH.
- TRAP: all strobes 0, `illegal`=1. Stays until reset.

## Timing
- Reset (async, while `rst_n`=0):
  - State FETCH, IR=`NOP_INSTR`, `illegal`=0.
  - All strobes 0, `alu_op`=0, selects 0, `instr_req`=1 once released.
- Outputs are combinational from state+IR. Exceptions: `pc_src` in BRANCH is combinational from the ALU flags (same cycle), and `illegal` is registered on TRAP entry.
- Latency with zero-wait memories: ALU/LUI/AUIPC 4 cycles; load 5; store 4; branch 3; jump 3. Each wait cycle on `instr_valid` or `mem_ready` adds one cycle.
- `mem_read`/`mem_write` never overlap, and are never asserted outside MEM.
- `instr_valid` outside FETCH is ignored, and IR is unchanged.
- Reset during MEM drops the strobes immediately. The next instruction is fetched from FETCH with no write committed.

## Structure
- Package `rv_ctrl_pkg`: state enum (FETCH, DECODE, EXEC, WB, ADDR, MEM, BRANCH, JUMP, TRAP), the 16 ALU code constants, opcode constants, and select encodings.
- Sub-module `alu_op_decode`: combinational mapping opcode/funct3/funct7 → ALU code + legal bit. It is shared with the EXEC and BRANCH paths.

## Test plan
- `add x3,x1,x2` (0x002081B3), `instr_valid` in first FETCH cycle → `alu_op`=0 in cycle 3, `reg_write`=1 and `pc_write`=1 in cycle 4, `instr_req` in cycle 5.
- `sub`/`sra`/`mul`/`srai`/`sltiu` → `alu_op` 1/8/2/8/A in EXEC, `alu_src_b` 0/0/0/1/1.
- `lw` with `mem_ready` held low 3 cycles → `mem_read` high exactly 4 cycles, then WB with `wb_sel`=1; total 8 cycles.
- `bltu` with `alu_less_than`=1, `alu_zero`=0 → `alu_op`=A, `pc_src`=1. `beq` with `alu_zero`=0 → `pc_src`=0, `reg_write`=0.
- `jalr x1,0(x5)` → `reg_write`=1, `wb_sel`=2, `alu_src_a`=0, `pc_src`=1 in cycle 3.
- OP with funct7 0100000 and funct3 001 → TRAP, `illegal`=1 sticky. Then `rst_n` low mid-MEM of a store → `mem_write` drops, `illegal`=0, IR=0x00000013.
